picosoc_dma_master: RTL and testbench

- Memory-copy engine acting as an initiator on the PicoSoC native memory bus (valid/ready, 32-bit, byte strobes).
- Copies LEN 32-bit words from a source to a destination, one read then one write per word.
- Lets firmware or a test harness move data between RAM and peripherals without CPU cycles.
- Sits beside the picorv32 core behind a bus arbiter; the arbiter is out of scope.

---
 rtl/picosoc_pkg.sv | 29 ++
 rtl/picosoc_bus_req.sv | 94 +++++++++
 rtl/picosoc_dma_master.sv | 177 +++++++++++++++++
 tb/tb_picosoc_dma_master.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/picosoc_pkg.sv
// -----------------------------------------------------------------------------
// picosoc_pkg
// Shared definitions for the PicoSoC DMA master and its bus request driver:
// bus widths, byte-strobe encodings, the copy-engine state enum and an
// address word-alignment helper.
// -----------------------------------------------------------------------------
package picosoc_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    localparam logic [3:0] WSTRB_READ = 4'h0;
    localparam logic [3:0] WSTRB_WORD = 4'hf;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_GAP,
        S_WR,
        S_WR_GAP,
        S_DONE
    } dma_state_t;

    // Force the two byte-offset bits to zero; the engine only moves whole words.
    function automatic logic [MEM_ADDR_W-1:0] word_align(input logic [MEM_ADDR_W-1:0] addr);
        return addr & ~MEM_ADDR_W'(3);
    endfunction

endpackage

// File: rtl/picosoc_bus_req.sv
// -----------------------------------------------------------------------------
// picosoc_bus_req
// Single-request driver for the PicoSoC native memory bus. A one-cycle
// i_launch loads address, write data and strobes into output registers and
// raises mem_valid on the next edge; the request is held stable until
// mem_ready is seen, then mem_valid drops on the following edge.
//
// Optional: `define DMA_TIMEOUT_EN adds a wait counter that abandons a request
// after TIMEOUT_CYCLES cycles of mem_valid=1 with mem_ready=0 (o_timeout).
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   i_launch         start a new request (only issued while idle on the bus)
//   i_addr/i_wdata/i_wstrb  request contents captured on launch
//   i_mem_ready      responder handshake
//   o_mem_valid/o_mem_addr/o_mem_wdata/o_mem_wstrb  registered bus request
//   o_ack            handshake completes this cycle (valid && ready)
//   o_timeout        request abandoned this cycle (always 0 without the feature)
// -----------------------------------------------------------------------------
module picosoc_bus_req
    import picosoc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_launch,
    input  logic [MEM_ADDR_W-1:0] i_addr,
    input  logic [MEM_DATA_W-1:0] i_wdata,
    input  logic [3:0]            i_wstrb,
    input  logic                  i_mem_ready,
    output logic                  o_mem_valid,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    output logic [MEM_DATA_W-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_wstrb,
    output logic                  o_ack,
    output logic                  o_timeout
);

    logic                  r_valid;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [MEM_DATA_W-1:0] r_wdata;
    logic [3:0]            r_wstrb;

    // A ready seen while no request is outstanding never counts.
    assign o_ack = r_valid && i_mem_ready;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples its inputs as they were before this edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (i_launch) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_wstrb <= i_wstrb;
        end else if (o_ack || o_timeout) begin
            // Contents stay put after the request ends; only valid drops.
            r_valid <= 1'b0;
        end
    end

`ifdef DMA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (!resetn || i_launch) begin
            r_wait_cnt <= '0;
        end else if (r_valid && !i_mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle of this request.
    assign o_timeout = r_valid && !i_mem_ready && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No timeout hardware: the request waits for mem_ready indefinitely. The
    // comparison is constant-false for every legal TIMEOUT_CYCLES and only
    // keeps the parameter referenced in this build.
    assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign o_mem_valid = r_valid;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_wstrb = r_wstrb;

endmodule

// File: rtl/picosoc_dma_master.sv
// -----------------------------------------------------------------------------
// picosoc_dma_master
// Memory-copy engine on the PicoSoC native bus. Copies len_words 32-bit words
// from src_addr to dst_addr, one read then one write per word, with a one-cycle
// mem_valid gap after every handshake. Bus requests go through
// picosoc_bus_req; this module sequences them and owns the copy counters.
//
// Optional: `define DMA_TIMEOUT_EN enables the bus wait timeout; on expiry the
// copy is abandoned, err is set and done pulses.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   start                 request a copy (accepted only in IDLE)
//   src_addr, dst_addr    byte addresses, bits [1:0] ignored
//   len_words             word count; zero completes with no bus traffic
//   busy, done, err       status: active, completion pulse, sticky abort
//   mem_valid ... mem_wstrb   native-bus request outputs
//   mem_ready, mem_rdata  native-bus response inputs
// -----------------------------------------------------------------------------
module picosoc_dma_master
    import picosoc_pkg::*;
#(
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] src_addr,
    input  logic [MEM_ADDR_W-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len_words,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_valid,
    output logic                  mem_instr,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [MEM_DATA_W-1:0] mem_rdata
);

    dma_state_t            r_state;
    dma_state_t            w_next_state;
    logic [MEM_ADDR_W-1:0] r_src_cur;
    logic [MEM_ADDR_W-1:0] r_dst_cur;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [MEM_DATA_W-1:0] r_buf;
    logic                  r_err;

    logic                  w_launch;
    logic [MEM_ADDR_W-1:0] w_req_addr;
    logic [MEM_DATA_W-1:0] w_req_wdata;
    logic [3:0]            w_req_wstrb;
    logic                  w_ack;
    logic                  w_timeout;
    logic                  w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    picosoc_bus_req #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_req (
        .clk         (clk),
        .resetn      (resetn),
        .i_launch    (w_launch),
        .i_addr      (w_req_addr),
        .i_wdata     (w_req_wdata),
        .i_wstrb     (w_req_wstrb),
        .i_mem_ready (mem_ready),
        .o_mem_valid (mem_valid),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_wstrb (mem_wstrb),
        .o_ack       (w_ack),
        .o_timeout   (w_timeout)
    );

    // Requests are launched from the cycle before RD/WR so that the registered
    // bus outputs are already valid in the first RD/WR cycle.
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_req_addr   = r_src_cur;
        w_req_wdata  = '0;
        w_req_wstrb  = WSTRB_READ;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len_words == '0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_RD;
                        w_launch     = 1'b1;
                        w_req_addr   = word_align(src_addr);
                    end
                end
            end
            S_RD: begin
                if (w_ack) begin
                    w_next_state = S_RD_GAP;
                end else if (w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_RD_GAP: begin
                w_next_state = S_WR;
                w_launch     = 1'b1;
                w_req_addr   = r_dst_cur;
                w_req_wdata  = r_buf;
                w_req_wstrb  = WSTRB_WORD;
            end
            S_WR: begin
                if (w_ack) begin
                    w_next_state = (r_remaining == LEN_WIDTH'(1)) ? S_DONE : S_WR_GAP;
                end else if (w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_WR_GAP: begin
                // r_src_cur was advanced on the write handshake.
                w_next_state = S_RD;
                w_launch     = 1'b1;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: the word buffer is an ordinary register, not a memory, so it is
    // cleared on reset along with the counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_src_cur   <= '0;
            r_dst_cur   <= '0;
            r_remaining <= '0;
            r_buf       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_src_cur   <= word_align(src_addr);
                r_dst_cur   <= word_align(dst_addr);
                r_remaining <= len_words;
                r_err       <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end

            if (r_state == S_RD && w_ack) begin
                r_buf <= mem_rdata;
            end

            // Address arithmetic wraps modulo 2^32 by construction.
            if (r_state == S_WR && w_ack) begin
                r_src_cur   <= r_src_cur + MEM_ADDR_W'(4);
                r_dst_cur   <= r_dst_cur + MEM_ADDR_W'(4);
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign mem_instr = 1'b0;

endmodule

// File: tb/tb_picosoc_dma_master.sv
// -----------------------------------------------------------------------------
// tb_picosoc_dma_master
// Self-checking bench for picosoc_dma_master. A 256-word memory model answers
// every request after a programmable number of wait cycles (0 = same-cycle
// ready). Each copy pushes its expected bus transactions into a scoreboard;
// a negedge monitor pops and compares them on every handshake and also checks
// request stability during waits and the one-cycle valid gap after ready.
// -----------------------------------------------------------------------------
module tb_picosoc_dma_master;

    localparam int LEN_WIDTH = 16;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 start;
    logic [31:0]          src_addr;
    logic [31:0]          dst_addr;
    logic [LEN_WIDTH-1:0] len_words;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 mem_valid;
    logic                 mem_instr;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_wstrb;
    logic                 mem_ready;
    logic [31:0]          mem_rdata;

    logic [31:0] mem [256];
    int          n_wait = 0;
    int          r_wait = 0;
    int          cyc    = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    txn_t        sb [$];

    txn_t        mon_t;
    logic        prev_valid = 1'b0;
    logic        prev_hs    = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_wdata = '0;
    logic [3:0]  prev_wstrb = '0;

    always #5 clk = ~clk;

    picosoc_dma_master #(
        .LEN_WIDTH      (LEN_WIDTH),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // Responder: ready once the request has waited n_wait cycles.
    assign mem_ready = mem_valid && (r_wait >= n_wait);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_valid && !mem_ready) r_wait <= r_wait + 1;
        else                         r_wait <= 0;
        if (mem_valid && mem_ready && mem_wstrb != 4'h0) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor and bus-protocol checks.
    always @(negedge clk) begin
        if (resetn) begin
            if (prev_hs) begin
                check("valid_gap", {31'd0, mem_valid}, 32'd0);
            end else if (prev_valid && mem_valid) begin
                check("hold_addr", mem_addr, prev_addr);
                check("hold_wdata", mem_wdata, prev_wdata);
                check("hold_wstrb", {28'd0, mem_wstrb}, {28'd0, prev_wstrb});
            end
            if (mem_valid && mem_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    mon_t = sb.pop_front();
                    check("bus_addr", mem_addr, mon_t.addr);
                    check("bus_wstrb", {28'd0, mem_wstrb}, mon_t.we ? 32'hf : 32'h0);
                    check("bus_wdata", mem_wdata, mon_t.data);
                end
            end
        end
        prev_valid = mem_valid && resetn;
        prev_hs    = mem_valid && mem_ready && resetn;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_wstrb = mem_wstrb;
    end

    // Preload source words, queue the expected read/write pairs, pulse start.
    task automatic kick(input logic [31:0] src, input logic [31:0] dst, input int len,
                        input int waits, input logic [31:0] first_word);
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] w;
        txn_t        t;
        s = src & 32'hFFFF_FFFC;
        d = dst & 32'hFFFF_FFFC;
        n_wait = waits;
        for (int i = 0; i < len; i++) begin
            a = s + 32'(4 * i);
            w = first_word + 32'(i) * 32'h11;
            mem[a[9:2]] <= w;
            t.we = 1'b0; t.addr = a;                 t.data = 32'h0; sb.push_back(t);
            t.we = 1'b1; t.addr = d + 32'(4 * i);    t.data = w;     sb.push_back(t);
        end
        @(negedge clk);
        start     = 1'b1;
        src_addr  = src;
        dst_addr  = dst;
        len_words = LEN_WIDTH'(len);
    endtask

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int waits, input int restart_at, input logic [31:0] first_word);
        int start_cyc;
        int first_valid = -1;
        int done_cyc    = -1;
        int busy_cycles = 0;
        int exp_cycles;
        kick(src, dst, len, waits, first_word);
        start_cyc  = cyc;
        exp_cycles = (len == 0) ? 1 : len * (4 + 2 * waits);
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (restart_at >= 2 && k == restart_at) begin
                start    = 1'b1;
                src_addr = 32'hDEAD_0000;
                dst_addr = 32'hDEAD_0100;
            end
            if (restart_at >= 2 && k == restart_at + 1) start = 1'b0;
            if (mem_valid && first_valid < 0) first_valid = cyc;
            if (busy) busy_cycles++;
            if (done) begin
                done_cyc = cyc;
                check("err_at_done", {31'd0, err}, 32'd0);
                break;
            end
        end
        if (done_cyc < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_at", 32'(done_cyc - start_cyc), 32'(exp_cycles));
            check("busy_len", 32'(busy_cycles), 32'(exp_cycles));
            // With the first mem_valid cycle counted as cycle 1, done lands on
            // cycle len*(4+2*waits).
            if (len == 0) check("no_bus", 32'(first_valid), 32'hFFFF_FFFF);
            else          check("latency", 32'(done_cyc - first_valid), 32'(exp_cycles - 1));
            @(negedge clk);
            check("done_width", {31'd0, done}, 32'd0);
            check("busy_after", {31'd0, busy}, 32'd0);
            check("sb_drained", 32'(sb.size()), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int done_seen;
        resetn    = 1'b0;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len_words = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("mem_instr", {31'd0, mem_instr}, 32'd0);
        resetn = 1'b1;

        // Zero-wait copy of 0xA1, 0xB2, 0xC3.
        run_copy(32'h100, 32'h200, 3, 0, -1, 32'hA1);
        // Empty copy: done one cycle after acceptance, no bus traffic.
        run_copy(32'h300, 32'h340, 0, 0, -1, 32'h0);
        // Three wait cycles per request.
        run_copy(32'h140, 32'h240, 2, 3, -1, 32'h1000_0001);
        // Second start while busy must be ignored.
        run_copy(32'h180, 32'h280, 3, 1, 5, 32'h2222_0000);
        // Source wraps past 2^32; destination offset bits dropped.
        run_copy(32'hFFFF_FFFC, 32'h103, 2, 0, -1, 32'h3333_0000);

        // Reset asserted for one cycle while a write is waiting.
        kick(32'h1C0, 32'h2C0, 4, 2, 32'h4444_0000);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_valid && mem_wstrb == 4'hf) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_mid_reached_wr", {31'd0, seen}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("rst_mid_no_done", 32'(done_seen), 32'd0);

        // Engine recovers after the abandoned transfer.
        run_copy(32'h1E0, 32'h2E0, 1, 0, -1, 32'h5A5A_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
